// File: rtl/vx_mem_pkg.sv
// Shared types and sizing helpers for the vx_mem_responder memory endpoint.
package vx_mem_pkg;

  localparam int unsigned MEM_DATA_WIDTH = 512;
  localparam int unsigned MEM_TAG_WIDTH  = 8;
  localparam int unsigned MEM_RSPQ_SIZE  = 8;

  localparam int unsigned BYTEEN_WIDTH = MEM_DATA_WIDTH / 8;

  // Width of a counter that must hold every value 0..depth inclusive.
  function automatic int unsigned credit_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  localparam int unsigned CREDIT_WIDTH = credit_width(MEM_RSPQ_SIZE);

  // One read response as it moves through the read pipeline and the queue.
  typedef struct packed {
    logic [MEM_DATA_WIDTH-1:0] data;
    logic [MEM_TAG_WIDTH-1:0]  tag;
  } rsp_entry_t;

endpackage

// File: rtl/vx_mem_responder_rspq.sv
// First-word-fall-through response queue; head is valid whenever empty is low.
// The caller must not push while full; pop on an empty queue is ignored.
module vx_mem_responder_rspq
  import vx_mem_pkg::*;
#(
  parameter int unsigned DEPTH = MEM_RSPQ_SIZE
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  rsp_entry_t                       push_data,
  input  logic                             pop,
  output rsp_entry_t                       head,
  output logic                             full,
  output logic                             empty,
  output logic [credit_width(DEPTH)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = credit_width(DEPTH);

  rsp_entry_t       store [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_pop;

  assign full   = (cnt == CNT_W'(DEPTH));
  assign empty  = (cnt == '0);
  assign do_pop = pop && !empty;
  assign head   = store[rd_ptr];
  assign count  = cnt;

  // Pointer and occupancy tracking; flushed by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; not reset, pointers define what is live.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vx_mem_responder.sv
// Memory-side endpoint: banked SRAM backing store, fixed-latency in-order reads,
// byte-masked writes, credit-based request flow control.
// Optional counters: define MEM_RESPONDER_PERF_EN to add perf_reads/perf_writes/perf_stalls.
// DATA_WIDTH and TAG_WIDTH must match the widths of vx_mem_pkg::rsp_entry_t.
module vx_mem_responder
  import vx_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned TAG_WIDTH  = MEM_TAG_WIDTH,
  parameter int unsigned DEPTH_LOG  = 12,
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned RSPQ_SIZE  = MEM_RSPQ_SIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_req_valid,
  input  logic                    mem_req_rw,
  input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic [DATA_WIDTH-1:0]   mem_req_data,
  input  logic [TAG_WIDTH-1:0]    mem_req_tag,
  output logic                    mem_req_ready,
  output logic                    mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
  input  logic                    mem_rsp_ready,
  output logic                    busy
`ifdef MEM_RESPONDER_PERF_EN
  ,
  output logic [63:0]             perf_reads,
  output logic [63:0]             perf_writes,
  output logic [63:0]             perf_stalls
`endif
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned CW    = credit_width(RSPQ_SIZE);
  localparam int unsigned LINES = 1 << DEPTH_LOG;
  // The SRAM read itself is the first latency stage; the rest are registers.
  localparam int unsigned NSTG  = (LATENCY > 1) ? LATENCY - 1 : 1;

  logic [DATA_WIDTH-1:0] sram [LINES];
  logic [DEPTH_LOG-1:0]  idx;
  logic                  req_fire;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  rsp_fire;
  logic [CW-1:0]         credits;
  rsp_entry_t            rd_entry;
  rsp_entry_t            push_entry;
  rsp_entry_t            head;
  logic                  push;
  logic [NSTG-1:0]       pipe_valid;
  logic                  q_full;
  logic                  q_empty;
  logic [CW-1:0]         q_count;

  assign idx           = mem_req_addr[DEPTH_LOG-1:0];
  assign mem_req_ready = (credits != '0) && !reset;
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rd_fire       = req_fire && !mem_req_rw;
  assign wr_fire       = req_fire && mem_req_rw;
  assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;

  // Upper line-address bits alias onto the stored lines.
  if (ADDR_WIDTH > DEPTH_LOG) begin : g_alias
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_req_addr[ADDR_WIDTH-1:DEPTH_LOG];
  end

  // Byte-masked write, visible to any read fired in a later cycle.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (mem_req_byteen[b]) sram[idx][b*8 +: 8] <= mem_req_data[b*8 +: 8];
      end
    end
  end

  // Same-cycle SRAM read paired with the request tag.
  always_comb begin
    rd_entry      = '0;
    rd_entry.data = sram[idx];
    rd_entry.tag  = mem_req_tag;
  end

  // Credits bound reads in flight plus queued responses to the queue depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      credits <= CW'(RSPQ_SIZE);
    end else begin
      case ({rd_fire, rsp_fire})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  if (LATENCY > 1) begin : g_pipe
    rsp_entry_t pipe_q [NSTG];

    // Valid shift chain; cleared on reset so in-flight reads are dropped.
    always_ff @(posedge clk) begin
      if (reset) begin
        pipe_valid <= '0;
      end else begin
        pipe_valid[0] <= rd_fire;
        for (int unsigned i = 1; i < NSTG; i++) pipe_valid[i] <= pipe_valid[i-1];
      end
    end

    // Payload shift chain; qualified by pipe_valid so no reset needed.
    always_ff @(posedge clk) begin
      pipe_q[0] <= rd_entry;
      for (int unsigned i = 1; i < NSTG; i++) pipe_q[i] <= pipe_q[i-1];
    end

    assign push       = pipe_valid[NSTG-1];
    assign push_entry = pipe_q[NSTG-1];
  end else begin : g_nopipe
    assign pipe_valid = '0;
    assign push       = rd_fire;
    assign push_entry = rd_entry;
  end

  vx_mem_responder_rspq #(
    .DEPTH (RSPQ_SIZE)
  ) u_rspq (
    .clk       (clk),
    .reset     (reset),
    .push      (push && !q_full),
    .push_data (push_entry),
    .pop       (mem_rsp_ready),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign mem_rsp_valid = !q_empty;
  assign mem_rsp_data  = head.data;
  assign mem_rsp_tag   = head.tag;
  assign busy          = (|pipe_valid) || (q_count != '0);

`ifdef MEM_RESPONDER_PERF_EN
  // Free-running event counters, wrapping modulo 2^64.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_reads  <= '0;
      perf_writes <= '0;
      perf_stalls <= '0;
    end else begin
      if (rd_fire) perf_reads  <= perf_reads  + 64'd1;
      if (wr_fire) perf_writes <= perf_writes + 64'd1;
      if (mem_req_valid && !mem_req_ready) perf_stalls <= perf_stalls + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_mem_responder.sv
// Directed bench for vx_mem_responder (default parameters, LATENCY=4, RSPQ_SIZE=8).
// Define MEM_RESPONDER_PERF_EN to also check the perf counters.
module tb_vx_mem_responder;

  localparam int unsigned DW = 512;
  localparam int unsigned AW = 26;
  localparam int unsigned TW = 8;
  localparam int unsigned BW = DW / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid;
  logic          req_rw;
  logic [BW-1:0] req_byteen;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic [TW-1:0] req_tag;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [TW-1:0] rsp_tag;
  logic          rsp_ready;
  logic          busy;
`ifdef MEM_RESPONDER_PERF_EN
  logic [63:0]   perf_reads;
  logic [63:0]   perf_writes;
  logic [63:0]   perf_stalls;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vx_mem_responder dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (req_valid),
    .mem_req_rw     (req_rw),
    .mem_req_byteen (req_byteen),
    .mem_req_addr   (req_addr),
    .mem_req_data   (req_data),
    .mem_req_tag    (req_tag),
    .mem_req_ready  (req_ready),
    .mem_rsp_valid  (rsp_valid),
    .mem_rsp_data   (rsp_data),
    .mem_rsp_tag    (rsp_tag),
    .mem_rsp_ready  (rsp_ready),
    .busy           (busy)
`ifdef MEM_RESPONDER_PERF_EN
    ,
    .perf_reads     (perf_reads),
    .perf_writes    (perf_writes),
    .perf_stalls    (perf_stalls)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string name, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", name, obs, exp);
    end
  endtask

  task automatic chk_val(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic idle();
    req_valid  = 1'b0;
    req_rw     = 1'b0;
    req_byteen = '0;
    req_addr   = '0;
    req_data   = '0;
    req_tag    = '0;
  endtask

  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [BW-1:0] be, input logic [TW-1:0] t);
    req_valid  = 1'b1;
    req_rw     = w;
    req_addr   = a;
    req_data   = d;
    req_byteen = be;
    req_tag    = t;
    chk_bit("ready_at_send", req_ready, 1'b1);
    tick();
    idle();
  endtask

  task automatic wait_rsp(input int budget);
    int n;
    n = 0;
    while (!rsp_valid && n < budget) begin
      tick();
      n++;
    end
    chk_bit("rsp_arrival", rsp_valid, 1'b1);
  endtask

  logic [TW-1:0] exp_q [$];
  logic          rdf;
  logic          rspf;
  int            acc;
  int            got;
  int            nt;
  logic [DW-1:0] exp_data;

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rsp_ready = 1'b1;
    reset     = 1'b1;
    tick();
    tick();

    // Reset state.
    chk_bit("reset_ready", req_ready, 1'b0);
    chk_bit("reset_rsp_valid", rsp_valid, 1'b0);
    chk_bit("reset_busy", busy, 1'b0);
    reset = 1'b0;
    #1;
    chk_bit("ready_after_reset", req_ready, 1'b1);

    // Full-line write then read: response exactly LATENCY cycles after the read fires.
    send(1'b1, AW'('h10), {64{8'hA5}}, '1, TW'(0));
    rsp_ready = 1'b0;
    send(1'b0, AW'('h10), '0, '0, TW'(3));
    chk_bit("busy_in_flight", busy, 1'b1);
    chk_bit("lat_t1", rsp_valid, 1'b0);
    tick();
    chk_bit("lat_t2", rsp_valid, 1'b0);
    tick();
    chk_bit("lat_t3", rsp_valid, 1'b0);
    tick();
    chk_bit("lat_t4", rsp_valid, 1'b1);
    chk_val("rd_data_a5", rsp_data, {64{8'hA5}});
    chk_val("rd_tag_3", DW'(rsp_tag), DW'(3));
    tick();
    chk_bit("hold_valid", rsp_valid, 1'b1);
    chk_val("hold_data", rsp_data, {64{8'hA5}});
    chk_val("hold_tag", DW'(rsp_tag), DW'(3));
    rsp_ready = 1'b1;
    tick();
    chk_bit("drained_valid", rsp_valid, 1'b0);
    chk_bit("drained_busy", busy, 1'b0);

    // Partial byte mask, zero mask no-op, and address aliasing.
    rsp_ready = 1'b0;
    send(1'b1, AW'(5), '0, '1, TW'(0));
    send(1'b1, AW'(5), {64{8'hFF}}, BW'(64'h0F), TW'(0));
    send(1'b1, AW'(5), {64{8'h11}}, '0, TW'(0));
    send(1'b1, AW'((1 << 12) | 7), {64{8'h3C}}, '1, TW'(0));
    send(1'b0, AW'(5), '0, '0, TW'(5));
    wait_rsp(10);
    chk_val("byteen_data", rsp_data, DW'(32'hFFFF_FFFF));
    chk_val("byteen_tag", DW'(rsp_tag), DW'(5));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    send(1'b0, AW'(7), '0, '0, TW'(7));
    wait_rsp(10);
    chk_val("alias_data", rsp_data, {64{8'h3C}});
    chk_val("alias_tag", DW'(rsp_tag), DW'(7));
    rsp_ready = 1'b1;
    tick();

    // Credit exhaustion: exactly 8 reads accepted with the consumer stalled.
    rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      req_valid = 1'b1;
      req_rw    = 1'b0;
      req_addr  = AW'(acc);
      req_tag   = TW'(acc);
      if (c == 8) chk_bit("full_ready_c8", req_ready, 1'b0);
      if (req_ready) acc++;
      tick();
    end
    idle();
    chk_val("full_accepted", DW'(acc), DW'(8));
    chk_bit("full_ready", req_ready, 1'b0);
    chk_bit("full_head_valid", rsp_valid, 1'b1);
    chk_val("full_head_tag", DW'(rsp_tag), DW'(0));
    rsp_ready = 1'b1;
    tick();
    chk_bit("ready_after_pop", req_ready, 1'b1);
    for (int k = 1; k < 8; k++) begin
      chk_bit("full_drain_valid", rsp_valid, 1'b1);
      chk_val("full_drain_tag", DW'(rsp_tag), DW'(k));
      tick();
    end
    chk_bit("full_empty_valid", rsp_valid, 1'b0);
    chk_bit("full_empty_busy", busy, 1'b0);

    // Random consumer backpressure: order, no loss/duplication, busy tracking.
    exp_q.delete();
    got = 0;
    nt  = 1;
    for (int c = 0; c < 200; c++) begin
      idle();
      if (c == 0 || c == 2 || c == 5) begin
        req_valid = 1'b1;
        req_addr  = AW'(nt);
        req_tag   = TW'(nt);
      end
      rsp_ready = 1'($urandom_range(0, 1));
      rdf  = req_valid && req_ready;
      rspf = rsp_valid && rsp_ready;
      if (rspf) begin
        if (exp_q.size() == 0) begin
          chk_bit("spurious_rsp", rsp_valid, 1'b0);
        end else begin
          chk_val("order_tag", DW'(rsp_tag), DW'(exp_q[0]));
          void'(exp_q.pop_front());
          got++;
        end
      end
      tick();
      if (rdf) begin
        exp_q.push_back(req_tag);
        nt++;
      end
      chk_bit("busy_track", busy, exp_q.size() != 0);
      if (c >= 6 && exp_q.size() == 0) break;
    end
    idle();
    chk_val("order_count", DW'(got), DW'(3));
    chk_bit("order_done_busy", busy, 1'b0);

    // Reset with 3 reads in the pipe and 2 queued, plus a write during reset.
    rsp_ready = 1'b1;
    send(1'b1, AW'(9), {64{8'h33}}, '1, TW'(0));
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(1'b0, AW'('h10), '0, '0, TW'(8'h20 + i));
    chk_bit("pre_reset_busy", busy, 1'b1);
    chk_bit("pre_reset_valid", rsp_valid, 1'b1);
    reset      = 1'b1;
    req_valid  = 1'b1;
    req_rw     = 1'b1;
    req_addr   = AW'(9);
    req_data   = {64{8'h77}};
    req_byteen = '1;
    #1;
    chk_bit("in_reset_ready", req_ready, 1'b0);
    tick();
    reset = 1'b0;
    idle();
    rsp_ready = 1'b1;
    #1;
    chk_bit("post_reset_valid", rsp_valid, 1'b0);
    chk_bit("post_reset_busy", busy, 1'b0);
    chk_bit("post_reset_ready", req_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_bit("no_stale_rsp", rsp_valid, 1'b0);
    end

    // 2 writes, 8 reads, then 3 stalled cycles; read back in order.
    rsp_ready = 1'b0;
    send(1'b1, AW'(20), {64{8'h5A}}, '1, TW'(0));
    send(1'b1, AW'(21), {64{8'hC3}}, '1, TW'(0));
    send(1'b0, AW'(9), '0, '0, TW'(8'h40));
    send(1'b0, AW'(20), '0, '0, TW'(8'h41));
    send(1'b0, AW'(21), '0, '0, TW'(8'h42));
    for (int i = 3; i < 8; i++) send(1'b0, AW'('h10), '0, '0, TW'(8'h40 + i));
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_bit("stall_ready", req_ready, 1'b0);
      tick();
    end
    idle();
`ifdef MEM_RESPONDER_PERF_EN
    chk_val("perf_reads", DW'(perf_reads), DW'(8));
    chk_val("perf_writes", DW'(perf_writes), DW'(2));
    chk_val("perf_stalls", DW'(perf_stalls), DW'(3));
`endif
    rsp_ready = 1'b1;
    wait_rsp(10);
    for (int k = 0; k < 8; k++) begin
      case (k)
        0:       exp_data = {64{8'h33}};
        1:       exp_data = {64{8'h5A}};
        2:       exp_data = {64{8'hC3}};
        default: exp_data = {64{8'hA5}};
      endcase
      chk_bit("final_valid", rsp_valid, 1'b1);
      chk_val("final_tag", DW'(rsp_tag), DW'(8'h40 + k));
      chk_val("final_data", rsp_data, exp_data);
      tick();
    end
    chk_bit("final_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
